// File: rtl/grey_scan_if.sv
// Pad-side bundle for grey_scan: Gray digit snapshot inputs and the
// multiplexed 7-segment display outputs.
interface grey_scan_if #(
    parameter int NDIG = 12
);
    logic [5*NDIG-1:0] DIGITS;
    logic              HOLD;
    logic [6:0]        SEG;
    logic              DP;
    logic [3:0]        DIG_IDX;
    logic              FRAME;

    modport master (
        output DIGITS,
        output HOLD,
        input  SEG,
        input  DP,
        input  DIG_IDX,
        input  FRAME
    );

    modport slave (
        input  DIGITS,
        input  HOLD,
        output SEG,
        output DP,
        output DIG_IDX,
        output FRAME
    );
endinterface

// File: rtl/grey_scan.sv
// Snapshots twelve Gray-coded decade digits once per frame and scans them onto a 7-segment bus.
// Optional leading-zero blanking is enabled by defining GREY_SCAN_LZB_EN.
module grey_scan #(
    parameter int DIV  = 4,
    parameter int NDIG = 12
) (
    input  logic      CLK,
    input  logic      RST,
    grey_scan_if.slave bus
);

    localparam int LAST = NDIG - 1;

    logic [15:0]        presc_q, presc_d;
    logic [3:0]         idx_q, idx_d;
    logic [5*NDIG-1:0]  snap_q, snap_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         dig_idx_q, dig_idx_d;
    logic               frame_q, frame_d;

    logic               tick;
    logic [4:0]         gray_cur;
    logic [4:0]         bin_cur;
    logic               blank;

    function automatic logic [4:0] gray2bin(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int k = 3; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    function automatic logic [6:0] glyph(input logic [4:0] v);
        case (v)
            5'd0:    glyph = 7'h3F;
            5'd1:    glyph = 7'h06;
            5'd2:    glyph = 7'h5B;
            5'd3:    glyph = 7'h4F;
            5'd4:    glyph = 7'h66;
            5'd5:    glyph = 7'h6D;
            5'd6:    glyph = 7'h7D;
            5'd7:    glyph = 7'h07;
            5'd8:    glyph = 7'h7F;
            5'd9:    glyph = 7'h6F;
            default: glyph = 7'h40;
        endcase
    endfunction

    always_comb begin
        tick    = (presc_q == 16'(DIV - 1));
        presc_d = tick ? 16'd0 : presc_q + 16'd1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == 4'(LAST)) ? 4'd0 : idx_q + 4'd1;
        end

        // Whole snapshot is taken in one edge so a frame never mixes two counter values.
        snap_d = snap_q;
        if (tick && (idx_q == 4'(LAST)) && !bus.HOLD) begin
            snap_d = bus.DIGITS;
        end

        gray_cur = 5'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == 4'(i)) begin
                gray_cur = snap_q[5*i +: 5];
            end
        end
        bin_cur = gray2bin(gray_cur);

        blank = 1'b0;
`ifdef GREY_SCAN_LZB_EN
        // Gray zero is binary zero; scan from the top so run_zero covers digits >= i.
        begin
            logic run_zero;
            run_zero = 1'b1;
            for (int i = LAST; i >= 0; i--) begin
                run_zero = run_zero && (snap_q[5*i +: 5] == 5'd0);
                if ((idx_q == 4'(i)) && (i != 0)) begin
                    blank = run_zero;
                end
            end
        end
`endif

        seg_d     = blank ? 7'h00 : glyph(bin_cur);
        dp_d      = !blank && ((idx_q == 4'd3) || (idx_q == 4'd6) || (idx_q == 4'd9));
        dig_idx_d = idx_q;
        frame_d   = (idx_q == 4'd0) && (dig_idx_q != 4'd0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q   <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            dig_idx_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_idx_q <= dig_idx_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.SEG     = seg_q;
    assign bus.DP      = dp_q;
    assign bus.DIG_IDX = dig_idx_q;
    assign bus.FRAME   = frame_q;

endmodule

// File: tb/tb_grey_scan.sv
// Directed bench for grey_scan: one instance at DIV=4 for the scan/decode/hold
// sequence, one at DIV=1 for the mid-frame reset case.
module tb_grey_scan;

    logic CLK = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 CLK = ~CLK;

    grey_scan_if #(.NDIG(12)) a_if ();
    grey_scan_if #(.NDIG(12)) b_if ();

    grey_scan #(.DIV(4), .NDIG(12)) u_a (.CLK(CLK), .RST(rst_a), .bus(a_if.slave));
    grey_scan #(.DIV(1), .NDIG(12)) u_b (.CLK(CLK), .RST(rst_b), .bus(b_if.slave));

    // Digit values in binary, digit 0 in the low five bits.
    localparam logic [59:0] V_ZERO = 60'd0;
    localparam logic [59:0] V_D1   = {50'd0, 5'd16, 5'd9};
    localparam logic [59:0] V_D2   = {30'd0, 5'd7, 15'd0, 5'd16, 5'd9};
    localparam logic [59:0] V_D3   = {5'd8, 5'd5, 5'd3, 5'd5, 5'd6, 5'd2,
                                      5'd9, 5'd5, 5'd1, 5'd4, 5'd1, 5'd3};
    localparam logic [59:0] V_D4   = {45'd0, 5'd4, 5'd0, 5'd7};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [59:0] to_gray(input logic [59:0] v);
        logic [59:0] g;
        logic [4:0]  d;
        for (int i = 0; i < 12; i++) begin
            d = v[5*i +: 5];
            g[5*i +: 5] = d ^ (d >> 1);
        end
        return g;
    endfunction

    function automatic logic is_blank(input logic [59:0] v, input int i);
        logic b;
        b = 1'b0;
`ifdef GREY_SCAN_LZB_EN
        b = (i != 0) && ((v >> (5*i)) == 60'd0);
`endif
        return b;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [59:0] v, input int i);
        logic [4:0] d;
        d = v[5*i +: 5];
        if (is_blank(v, i)) return 7'h00;
        case (d)
            5'd0: return 7'h3F;
            5'd1: return 7'h06;
            5'd2: return 7'h5B;
            5'd3: return 7'h4F;
            5'd4: return 7'h66;
            5'd5: return 7'h6D;
            5'd6: return 7'h7D;
            5'd7: return 7'h07;
            5'd8: return 7'h7F;
            5'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic exp_dp(input logic [59:0] v, input int i);
        return !is_blank(v, i) && (i == 3 || i == 6 || i == 9);
    endfunction

    task automatic check_a(input string nm, input logic [59:0] v, input int i);
        check($sformatf("%s_idx%0d", nm, i),   32'(a_if.DIG_IDX), 32'(i));
        check($sformatf("%s_seg%0d", nm, i),   32'(a_if.SEG),     32'(exp_seg(v, i)));
        check($sformatf("%s_dp%0d", nm, i),    32'(a_if.DP),      32'(exp_dp(v, i)));
        check($sformatf("%s_frame%0d", nm, i), 32'(a_if.FRAME),   32'(i == 0));
    endtask

    task automatic check_b(input string nm, input logic [59:0] v, input int i);
        check($sformatf("%s_idx%0d", nm, i),   32'(b_if.DIG_IDX), 32'(i));
        check($sformatf("%s_seg%0d", nm, i),   32'(b_if.SEG),     32'(exp_seg(v, i)));
        check($sformatf("%s_dp%0d", nm, i),    32'(b_if.DP),      32'(exp_dp(v, i)));
        check($sformatf("%s_frame%0d", nm, i), 32'(b_if.FRAME),   32'(i == 0));
    endtask

    // Entered at the sample point of digit 0; leaves at digit 0 of the next frame.
    task automatic scan_frame(input string nm, input logic [59:0] v, input int chg_at,
                              input logic [59:0] chg_v, input logic chg_hold);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                repeat (4) @(posedge CLK);
                #1;
            end
            check_a(nm, v, i);
            if (i == chg_at) begin
                a_if.DIGITS = to_gray(chg_v);
                a_if.HOLD   = chg_hold;
            end
        end
        repeat (4) @(posedge CLK);
        #1;
    endtask

    initial begin
        a_if.DIGITS = '0;
        a_if.HOLD   = 1'b0;
        b_if.DIGITS = to_gray(V_D3);
        b_if.HOLD   = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_seg",   32'(a_if.SEG),     32'h0);
        check("rst_dp",    32'(a_if.DP),      32'h0);
        check("rst_idx",   32'(a_if.DIG_IDX), 32'h0);
        check("rst_frame", 32'(a_if.FRAME),   32'h0);

        rst_a = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 12; k++) begin
            repeat (4) @(posedge CLK);
            #1;
            check_a("idle", V_ZERO, k % 12);
        end

        scan_frame("fa", V_ZERO, 0, V_D1, 1'b0);
        scan_frame("fb", V_D1,   2, V_D2, 1'b0);
        scan_frame("fc", V_D2,   4, V_D3, 1'b1);
        scan_frame("fd", V_D2,   6, V_D3, 1'b0);
        scan_frame("fe", V_D3,   1, V_D4, 1'b0);
        scan_frame("ff", V_D4,   1, V_ZERO, 1'b0);
        scan_frame("fg", V_ZERO, -1, V_ZERO, 1'b0);

        // DIV=1 instance: let it load V_D3, then reset it while showing digit 7.
        rst_b = 1'b1;
        repeat (30) @(posedge CLK);
        begin
            logic found;
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                @(posedge CLK);
                #1;
                if (b_if.DIG_IDX == 4'd7) found = 1'b1;
            end
            check("b_reach_idx7", 32'(found), 32'd1);
        end
        check("b_pre_seg7", 32'(b_if.SEG), 32'(exp_seg(V_D3, 7)));
        #2 rst_b = 1'b0;
        #1;
        check("brst_seg",   32'(b_if.SEG),     32'h0);
        check("brst_dp",    32'(b_if.DP),      32'h0);
        check("brst_idx",   32'(b_if.DIG_IDX), 32'h0);
        check("brst_frame", 32'(b_if.FRAME),   32'h0);
        #2 rst_b = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK);
            #1;
            check_b("brun", (k == 12) ? V_D3 : V_ZERO, k % 12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grey_scan.md
# grey_scan

Display scanner that sits directly downstream of the 12-digit Gray-coded decade counter. It captures the twelve 5-bit Gray-coded digits as one coherent snapshot per frame and decodes each to binary. It then time-multiplexes the digits onto a single 7-segment output with a digit index, a decimal-point separator and a frame strobe, so the counter value can be shown on an 8-bit pad bus.

## Interface
- `DIV`, default 4: scan prescaler; the display advances one digit every `DIV` clocks; legal range 1..65535.
- `NDIG`, default 12: digits per frame; fixed at 12 for this design.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `DIGITS` input 60: digit i is `DIGITS[5i+4:5i]`; digit 0 is ones, digit 11 is hundred-billions; each digit is reflected-Gray coded.
- `HOLD` input 1: when high, the snapshot is not reloaded at frame wrap.
- `SEG` output 7: segments {g,f,e,d,c,b,a}, active-high, registered.
- `DP` output 1: separator point, registered.
- `DIG_IDX` output 4: index of the digit currently on `SEG`, registered.
- `FRAME` output 1: one-clock pulse when `DIG_IDX` becomes 0.

## Operation
- Prescaler counts 0..DIV-1 and wraps; `tick` asserts when count = DIV-1. With `DIV` = 1, `tick` asserts every cycle.
- Scan counter `idx` advances on `tick`: 0→1→…→11→0.
- On the `tick` where `idx` wraps 11→0 with `HOLD` low, `snap` ← `DIGITS` (all 60 bits in the same edge). `DIGITS` changes at any other time have no effect.
- Decode: b4 = g4 and bi = b(i+1) ^ gi, giving value v = b.
- Segment map for v = 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex). Any v ≥ 10 is invalid and shows dash 40.
- `DP` = 1 when the displayed index is 3, 6 or 9 (thousands separators).
- Output stage: on the clock after `idx` changes, `SEG`, `DP` and `DIG_IDX` load together from `snap[idx]`, so the three outputs are always mutually consistent. `FRAME` = 1 on exactly that cycle when the new `DIG_IDX` = 0.

## Timing
- Reset (`RST` low, asynchronous): prescaler = 0, `idx` = 0, `snap` = 0, `SEG` = 00, `DP` = 0, `DIG_IDX` = 0, `FRAME` = 0.
- After reset release, the first `tick` occurs at clock edge DIV, and `idx` becomes 1. The outputs show digit 1 of the zero snapshot one clock later. Digit 0 is shown first after the first wrap.
- Latency: `DIGITS` sampled at the wrap edge appears on `SEG` (digit 0) one clock later, alongside `FRAME`.
- Frame period = 12·DIV clocks; `FRAME` period is identical.
- `HOLD` is sampled only at the wrap edge. Raising it mid-frame freezes the next snapshot; the current frame is unaffected.
- Reset mid-frame aborts the scan immediately; no partial snapshot is retained.

## Configuration
- `GREY_SCAN_LZB_EN` defined: leading-zero blanking is enabled.
  - Digit i (i ≥ 1) is blanked (`SEG` = 00, `DP` = 0) when every snapshot digit j ≥ i decodes to v = 0.
  - Invalid digits count as non-zero.
  - Digit 0 is never blanked.
  - Blanking is evaluated from `snap`, so it is stable for the whole frame.
- Macro undefined: no blanking; every digit shows its decoded glyph, and `DP` follows the index rule only.

## Test plan
- Reset and idle: hold `RST` low, then release with `DIV` = 4 and `DIGITS` = 0. Required: all outputs 0 during reset. Without `GREY_SCAN_LZB_EN`, `DIG_IDX` steps 1,2,…,11,0 every 4 clocks, `SEG` = 3F throughout, `DP` = 1 only at indices 3, 6 and 9.
- Decode: set digit 0 = 01101 (Gray for 9) and digit 1 = 11000 (decodes to 16). Required: after the next wrap, `SEG` = 6F at index 0 and `SEG` = 40 at index 1.
- Snapshot coherence: change digit 5 while `DIG_IDX` = 2. Required: the old value is shown at index 5 in this frame; the new value appears at index 5 in the next frame, and `FRAME` pulses at index 0 of that frame.
- Hold: raise `HOLD` before a wrap and change `DIGITS`. Required: the display repeats the old values. After `HOLD` falls, the new values appear after the following wrap.
- LZB (macro defined): set digits = 7 at index 0, 4 at index 2, and 0 elsewhere. Required: indices 0..2 show 07, 3F, 66; indices 3..11 show `SEG` = 00 and `DP` = 0. With an all-zero snapshot, only index 0 shows 3F.
- Mid-frame reset with `DIV` = 1: assert `RST` at `DIG_IDX` = 7. Required: outputs are 0 immediately and the scan restarts from the zero snapshot.
